// File: rtl/bit_timer_pkg.sv
// bit_timer_pkg: shared widths, defaults and parameter limits
// for the bit-period timer of the serial receive path.
`timescale 1ns/10ps
package bit_timer_pkg;

   localparam int TIMER_CNT_BITS   = 4;

   localparam int DEF_CLKS_PER_BIT = 10;
   localparam int DEF_DATA_BITS    = 8;

   localparam int MIN_CLKS_PER_BIT = 2;
   localparam int MAX_CLKS_PER_BIT = 15;
   localparam int MIN_DATA_BITS    = 1;
   localparam int MAX_DATA_BITS    = 14;

   function automatic bit params_ok(
      input int clks,
      input int data
   );
      return (clks >= MIN_CLKS_PER_BIT) &&
             (clks <= MAX_CLKS_PER_BIT) &&
             (data >= MIN_DATA_BITS) &&
             (data <= MAX_DATA_BITS);
   endfunction

endpackage

// File: rtl/flex_counter.sv
// flex_counter: loadable-limit up counter, wraps to 1 after
// rollover_val; rollover_flag is registered and high while count == limit.
`timescale 1ns/10ps
module flex_counter #(
   parameter int NUM_BITS = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                clear,
   input  logic                count_enable,
   input  logic [NUM_BITS-1:0] rollover_val,
   output logic [NUM_BITS-1:0] count_out,
   output logic                rollover_flag
);

   logic [NUM_BITS-1:0] next_count;
   logic                next_flag;

   always_comb begin
      next_count = count_out;
      if (clear) begin
         next_count = '0;
      end else if (count_enable) begin
         if (count_out == rollover_val)
            next_count = NUM_BITS'(1);
         else
            next_count = count_out + 1'b1;
      end
      next_flag = (next_count == rollover_val);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_out     <= '0;
         rollover_flag <= 1'b0;
      end else begin
         count_out     <= next_count;
         rollover_flag <= next_flag;
      end
   end

endmodule

// File: rtl/bit_timer.sv
// bit_timer: per-bit shift strobe and packet bit count for the rx path.
// Define BIT_TIMER_DONE_PULSE_EN for a single-cycle packet_done pulse.
`timescale 1ns/10ps
module bit_timer
   import bit_timer_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      enable_timer,
   output logic                      shift_strobe,
   output logic [TIMER_CNT_BITS-1:0] bit_count,
   output logic                      packet_done
);

   localparam logic [TIMER_CNT_BITS-1:0] CLK_ROLL =
      TIMER_CNT_BITS'(CLKS_PER_BIT);
   localparam logic [TIMER_CNT_BITS-1:0] BIT_ROLL =
      TIMER_CNT_BITS'(DATA_BITS + 1);

   if (!params_ok(CLKS_PER_BIT, DATA_BITS)) begin : g_param_err
      $error("bit_timer: CLKS_PER_BIT or DATA_BITS out of range");
   end

   logic                      clear;
   logic [TIMER_CNT_BITS-1:0] clk_count;
   logic                      bits_full;

   assign clear = !enable_timer;

   flex_counter #(
      .NUM_BITS (TIMER_CNT_BITS)
   ) u_clk_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear),
      .count_enable  (enable_timer),
      .rollover_val  (CLK_ROLL),
      .count_out     (clk_count),
      .rollover_flag (shift_strobe)
   );

   flex_counter #(
      .NUM_BITS (TIMER_CNT_BITS)
   ) u_bit_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear),
      .count_enable  (shift_strobe),
      .rollover_val  (BIT_ROLL),
      .count_out     (bit_count),
      .rollover_flag (bits_full)
   );

`ifdef BIT_TIMER_DONE_PULSE_EN
   logic done_pulse;

   // bits_full always rises as the clock count wraps to 1, so that
   // phase marks the first full cycle of a completed packet.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         done_pulse <= 1'b0;
      else
         done_pulse <= bits_full && enable_timer &&
                       (clk_count == TIMER_CNT_BITS'(1));
   end

   assign packet_done = done_pulse;
`else
   assign packet_done = bits_full;
`endif

   a_clk_range : assert property (
      @(posedge clk) disable iff (!n_rst)
      clk_count <= CLK_ROLL
   );

   a_bit_range : assert property (
      @(posedge clk) disable iff (!n_rst)
      bit_count <= BIT_ROLL
   );

endmodule

// File: tb/tb_bit_timer.sv
// tb_bit_timer: random and directed enable/reset stimulus, scoreboard
// against an arithmetic model for the default and minimum configs.
`timescale 1ns/10ps
module tb_bit_timer;

   localparam int C0 = 10;
   localparam int D0 = 8;
   localparam int C1 = 2;
   localparam int D1 = 1;

   typedef struct {
      int s0;
      int bc0;
      int d0;
      int s1;
      int bc1;
      int d1;
   } exp_t;

   logic       tb_clk;
   logic       n_rst;
   logic       en;
   logic       s0;
   logic [3:0] bc0;
   logic       d0;
   logic       s1;
   logic [3:0] bc1;
   logic       d1;

   exp_t sb[$];
   int   mdl_n;
   int   n_checks;
   int   n_fail;

   bit_timer dut (
      .clk          (tb_clk),
      .n_rst        (n_rst),
      .enable_timer (en),
      .shift_strobe (s0),
      .bit_count    (bc0),
      .packet_done  (d0)
   );

   bit_timer #(
      .CLKS_PER_BIT (C1),
      .DATA_BITS    (D1)
   ) dut_min (
      .clk          (tb_clk),
      .n_rst        (n_rst),
      .enable_timer (en),
      .shift_strobe (s1),
      .bit_count    (bc1),
      .packet_done  (d1)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   // mdl_n = consecutive edges that sampled enable high out of reset
   function automatic int bc_of(int n, int c, int d);
      int ended;
      if (n < 1) return 0;
      ended = (n - 1) / c;
      if (ended == 0) return 0;
      return ((ended - 1) % (d + 1)) + 1;
   endfunction

   function automatic int strobe_of(int n, int c);
      return (n > 0 && n % c == 0) ? 1 : 0;
   endfunction

   function automatic int done_of(int n, int c, int d);
`ifdef BIT_TIMER_DONE_PULSE_EN
      return (n >= 2 && bc_of(n - 1, c, d) == d + 1 &&
              bc_of(n - 2, c, d) != d + 1) ? 1 : 0;
`else
      return (bc_of(n, c, d) == d + 1) ? 1 : 0;
`endif
   endfunction

   function automatic void push();
      exp_t e;
      e.s0  = strobe_of(mdl_n, C0);
      e.bc0 = bc_of(mdl_n, C0, D0);
      e.d0  = done_of(mdl_n, C0, D0);
      e.s1  = strobe_of(mdl_n, C1);
      e.bc1 = bc_of(mdl_n, C1, D1);
      e.d1  = done_of(mdl_n, C1, D1);
      sb.push_back(e);
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic compare_head();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk("strobe", int'(s0), e.s0);
         chk("bit_count", int'(bc0), e.bc0);
         chk("packet_done", int'(d0), e.d0);
         chk("min_strobe", int'(s1), e.s1);
         chk("min_bit_count", int'(bc1), e.bc1);
         chk("min_packet_done", int'(d1), e.d1);
      end
   endtask

   initial forever begin
      @(negedge tb_clk);
      compare_head();
   end

   initial forever begin
      @(negedge n_rst);
      #0.1;
      compare_head();
   end

   task automatic step();
      @(posedge tb_clk);
      if (!n_rst || !en) mdl_n = 0;
      else mdl_n++;
      push();
   endtask

   task automatic step_drive();
      step();
      #1;
   endtask

   task automatic pulse_reset();
      #5;
      mdl_n = 0;
      push();
      n_rst = 1'b0;
      repeat (2) step();
      #1 n_rst = 1'b1;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      mdl_n    = 0;
      en       = 1'b0;
      n_rst    = 1'b1;
      #2;
      push();
      n_rst = 1'b0;
      step();
      #1;
      en    = 1'b1;
      n_rst = 1'b1;

      // full packet, then overrun past the done point
      repeat (115) step_drive();

      // abort after the third strobe, then restart
      en = 1'b0;
      repeat (2) step_drive();
      en = 1'b1;
      for (int i = 0; i < 40 && mdl_n != 31; i++) step_drive();
      chk("abort_point", mdl_n, 31);
      en = 1'b0;
      repeat (2) step_drive();
      en = 1'b1;
      repeat (15) step_drive();

      // asynchronous reset at clock count 5
      en = 1'b0;
      step_drive();
      en = 1'b1;
      repeat (5) step_drive();
      pulse_reset();
      repeat (30) step_drive();

      for (int r = 0; r < 12; r++) begin
         en = 1'b1;
         repeat ($urandom_range(1, 120)) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else step_drive();
         end
         en = 1'b0;
         repeat ($urandom_range(1, 4)) step_drive();
      end

      @(negedge tb_clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
